// File: rtl/mux_2to1_8bits_arbiter.sv
// rtl/mux_2to1_8bits_arbiter.sv - two-channel buffered round-robin arbiter feeding a registered 2:1 output
module mux_2to1_8bits_arbiter #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] IN1,
  input  logic          IN1_VALID,
  output logic          IN1_READY,
  input  logic [DW-1:0] IN2,
  input  logic          IN2_VALID,
  output logic          IN2_READY,
  output logic [DW-1:0] OUT,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          SEL,
  output logic [CW-1:0] XFER_CNT
);

  // One-entry skid buffers, one per input channel
  logic          b1_vld_q, b1_vld_d;
  logic [DW-1:0] b1_dat_q, b1_dat_d;
  logic          b2_vld_q, b2_vld_d;
  logic [DW-1:0] b2_dat_q, b2_dat_d;

  // Output register, source tag, round-robin pointer and transfer counter
  logic [DW-1:0] out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic acc1, acc2, xfer, load_en, pick;

  // Handshake qualifiers and the round-robin choice between the two buffers
  always_comb begin
    acc1    = IN1_VALID & ~b1_vld_q;
    acc2    = IN2_VALID & ~b2_vld_q;
    xfer    = out_vld_q & OUT_READY;
    load_en = (~out_vld_q | OUT_READY) & (b1_vld_q | b2_vld_q);
    // On a tie the channel not served last wins; otherwise the only full buffer wins
    if (b1_vld_q && b2_vld_q) begin
      pick = ~last_q;
    end else begin
      pick = b2_vld_q;
    end
  end

  // Next-state: output load or drain, buffer capture, transfer count
  always_comb begin
    b1_vld_d  = b1_vld_q;
    b1_dat_d  = b1_dat_q;
    b2_vld_d  = b2_vld_q;
    b2_dat_d  = b2_dat_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;

    if (load_en) begin
      out_d     = pick ? b2_dat_q : b1_dat_q;
      out_vld_d = 1'b1;
      sel_d     = pick;
      last_d    = pick;
      if (pick) begin
        b2_vld_d = 1'b0;
      end else begin
        b1_vld_d = 1'b0;
      end
    end else if (xfer) begin
      // Word taken and nothing to replace it: OUT and SEL keep their last values
      out_vld_d = 1'b0;
    end

    // A buffer can only accept while empty, so it never collides with a load from itself
    if (acc1) begin
      b1_vld_d = 1'b1;
      b1_dat_d = IN1;
    end
    if (acc2) begin
      b2_vld_d = 1'b1;
      b2_dat_d = IN2;
    end

    if (xfer) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // State registers; reset discards every buffered and held word
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      b1_vld_q  <= 1'b0;
      b1_dat_q  <= '0;
      b2_vld_q  <= 1'b0;
      b2_dat_q  <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
    end else begin
      b1_vld_q  <= b1_vld_d;
      b1_dat_q  <= b1_dat_d;
      b2_vld_q  <= b2_vld_d;
      b2_dat_q  <= b2_dat_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  // Ready comes straight from the buffer-valid flops, no input-to-output path
  assign IN1_READY = ~b1_vld_q;
  assign IN2_READY = ~b2_vld_q;
  assign OUT       = out_q;
  assign OUT_VALID = out_vld_q;
  assign SEL       = sel_q;
  assign XFER_CNT  = cnt_q;

endmodule
